// File: rtl/store_write_buffer_if.sv
// rtl/store_write_buffer_if.sv - store-side, memory-side and forwarding signals of the write buffer
interface store_write_buffer_if #(parameter int PTR_W = 2);
  logic             storeValid;
  logic [15:0]      storeAddress;
  logic [15:0]      storeData;
  logic             storeReady;
  logic             memWriteEnable;
  logic [15:0]      memAddress;
  logic [15:0]      memData;
  logic             memAck;
  logic [15:0]      loadAddress;
  logic             forwardHit;
  logic [15:0]      forwardData;
  logic [PTR_W:0]   bufferCount;
  logic             bufferEmpty;

  modport master (
    output storeValid, storeAddress, storeData, memAck, loadAddress,
    input  storeReady, memWriteEnable, memAddress, memData,
           forwardHit, forwardData, bufferCount, bufferEmpty
  );

  modport slave (
    input  storeValid, storeAddress, storeData, memAck, loadAddress,
    output storeReady, memWriteEnable, memAddress, memData,
           forwardHit, forwardData, bufferCount, bufferEmpty
  );
endinterface

// File: rtl/store_write_buffer.sv
// rtl/store_write_buffer.sv - in-order store queue draining to data memory, with youngest-match load forwarding
module store_write_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  store_write_buffer_if.slave   bus
);

  logic [15:0]      addr_q [DEPTH];
  logic [15:0]      data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  logic             enq;
  logic             deq;
  logic             empty;
  logic             hit;
  logic [15:0]      fwd_data;
  logic [PTR_W-1:0] idx;

  assign empty = (count == '0);
  // Ready comes only from registered count, so a full buffer never accepts even while draining.
  assign bus.storeReady     = (count != (PTR_W+1)'(DEPTH));
  assign bus.bufferEmpty    = empty;
  assign bus.bufferCount    = count;
  assign bus.memWriteEnable = !empty;
  assign bus.memAddress     = empty ? 16'h0000 : addr_q[rd_ptr];
  assign bus.memData        = empty ? 16'h0000 : data_q[rd_ptr];
  assign bus.forwardHit     = hit;
  assign bus.forwardData    = fwd_data;

  assign enq = bus.storeValid && bus.storeReady;
  assign deq = !empty && bus.memAck;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= 16'h0000;
        data_q[i] <= 16'h0000;
      end
    end else begin
      if (enq) begin
        addr_q[wr_ptr]  <= bus.storeAddress;
        data_q[wr_ptr]  <= bus.storeData;
        valid_q[wr_ptr] <= 1'b1;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (deq) begin
        valid_q[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + 1'b1;
      end
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Walk oldest to youngest so the last match seen is the youngest store.
  always_comb begin
    hit      = 1'b0;
    fwd_data = 16'h0000;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if (valid_q[idx] && (addr_q[idx] == bus.loadAddress)) begin
        hit      = 1'b1;
        fwd_data = data_q[idx];
      end
    end
  end

endmodule

// File: tb/tb_store_write_buffer.sv
// tb/tb_store_write_buffer.sv - directed self-checking bench for store_write_buffer
module tb_store_write_buffer;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  logic [31:0] log_q [$];
  logic [31:0] exp_q [$];
  int   max_cnt;
  int   n;

  store_write_buffer_if #(.PTR_W(2)) bus ();

  store_write_buffer #(.DEPTH(4), .PTR_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Writes are committed at the next rising edge; inputs are stable at the falling edge.
  always @(negedge clk)
    if (rst_n && bus.memWriteEnable && bus.memAck)
      log_q.push_back({bus.memAddress, bus.memData});

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [15:0] a, input logic [15:0] d);
    bus.storeValid   = 1'b1;
    bus.storeAddress = a;
    bus.storeData    = d;
    step();
    bus.storeValid   = 1'b0;
  endtask

  task automatic drain();
    bus.memAck = 1'b1;
    n = 0;
    while (!bus.bufferEmpty && n < 20) begin
      step();
      n++;
    end
    bus.memAck = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    bus.storeValid   = 1'b0;
    bus.storeAddress = 16'h0000;
    bus.storeData    = 16'h0000;
    bus.memAck       = 1'b0;
    bus.loadAddress  = 16'h0000;
    #2;
    check("rst_ready", bus.storeReady, 1);
    check("rst_mwe",   bus.memWriteEnable, 0);
    check("rst_maddr", bus.memAddress, 0);
    check("rst_mdata", bus.memData, 0);
    check("rst_hit",   bus.forwardHit, 0);
    check("rst_fdata", bus.forwardData, 0);
    check("rst_count", bus.bufferCount, 0);
    check("rst_empty", bus.bufferEmpty, 1);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Single store held unacknowledged for three cycles
    store(16'h0040, 16'hBEEF);
    exp_q.push_back(32'h0040_BEEF);
    for (int i = 0; i < 3; i++) begin
      check("single_mwe",   bus.memWriteEnable, 1);
      check("single_maddr", bus.memAddress, 16'h0040);
      check("single_mdata", bus.memData, 16'hBEEF);
      if (i < 2) step();
    end
    bus.memAck = 1'b1;
    step();
    bus.memAck = 1'b0;
    check("single_empty", bus.bufferEmpty, 1);
    check("single_log",   log_q.size(), 1);

    // Fill to capacity, then overlap enqueue attempt with a dequeue
    store(16'h0010, 16'h1111);
    store(16'h0011, 16'h2222);
    store(16'h0012, 16'h3333);
    store(16'h0013, 16'h4444);
    exp_q.push_back(32'h0010_1111);
    exp_q.push_back(32'h0011_2222);
    exp_q.push_back(32'h0012_3333);
    exp_q.push_back(32'h0013_4444);
    check("full_ready", bus.storeReady, 0);
    check("full_count", bus.bufferCount, 4);
    bus.storeValid   = 1'b1;
    bus.storeAddress = 16'h0050;
    bus.storeData    = 16'h5555;
    step();
    check("full_ignored_count", bus.bufferCount, 4);
    check("full_head", bus.memAddress, 16'h0010);
    bus.memAck = 1'b1;
    step();
    bus.memAck = 1'b0;
    check("full_one_write", log_q.size(), 2);
    check("full_after_ack_count", bus.bufferCount, 3);
    step();
    bus.storeValid = 1'b0;
    exp_q.push_back(32'h0050_5555);
    check("full_stalled_accepted", bus.bufferCount, 4);
    drain();
    check("full_drained", bus.bufferEmpty, 1);

    // Wrap-around with memory always acknowledging
    bus.memAck = 1'b1;
    max_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      store(16'h0100 + 16'(i), 16'hA000 + 16'(i));
      exp_q.push_back({16'h0100 + 16'(i), 16'hA000 + 16'(i)});
      if (int'(bus.bufferCount) > max_cnt) max_cnt = int'(bus.bufferCount);
    end
    step();
    bus.memAck = 1'b0;
    check("wrap_max_count", max_cnt, 1);
    check("wrap_empty", bus.bufferEmpty, 1);

    // Forwarding
    store(16'h0020, 16'hAAAA);
    store(16'h0030, 16'hBBBB);
    store(16'h0020, 16'hCCCC);
    bus.loadAddress = 16'h0020;
    #1;
    check("fwd20_hit",  bus.forwardHit, 1);
    check("fwd20_data", bus.forwardData, 16'hCCCC);
    bus.loadAddress = 16'h0030;
    #1;
    check("fwd30_hit",  bus.forwardHit, 1);
    check("fwd30_data", bus.forwardData, 16'hBBBB);
    bus.loadAddress = 16'h0040;
    #1;
    check("fwd40_hit",  bus.forwardHit, 0);
    check("fwd40_data", bus.forwardData, 0);
    bus.storeValid   = 1'b1;
    bus.storeAddress = 16'h0040;
    bus.storeData    = 16'hDDDD;
    #1;
    check("fwd_same_cycle_hit", bus.forwardHit, 0);
    step();
    bus.storeValid = 1'b0;
    check("fwd_after_edge_hit",  bus.forwardHit, 1);
    check("fwd_after_edge_data", bus.forwardData, 16'hDDDD);

    // Drop to two entries, then enqueue and dequeue together
    bus.memAck = 1'b1;
    step();
    step();
    exp_q.push_back(32'h0020_AAAA);
    exp_q.push_back(32'h0030_BBBB);
    check("sim_pre_count", bus.bufferCount, 2);
    bus.storeValid   = 1'b1;
    bus.storeAddress = 16'h0060;
    bus.storeData    = 16'h6666;
    step();
    bus.storeValid = 1'b0;
    bus.memAck     = 1'b0;
    exp_q.push_back(32'h0020_CCCC);
    check("sim_count", bus.bufferCount, 2);
    check("sim_head_addr", bus.memAddress, 16'h0040);
    check("sim_head_data", bus.memData, 16'hDDDD);
    bus.loadAddress = 16'h0060;
    #1;
    check("sim_wr_fwd", bus.forwardData, 16'h6666);

    // Asynchronous reset with three pending stores
    store(16'h0070, 16'h7777);
    check("rst3_pre_count", bus.bufferCount, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst3_mwe",   bus.memWriteEnable, 0);
    check("rst3_count", bus.bufferCount, 0);
    check("rst3_ready", bus.storeReady, 1);
    check("rst3_empty", bus.bufferEmpty, 1);
    step();
    rst_n = 1'b1;
    bus.memAck = 1'b1;
    repeat (5) step();
    bus.memAck = 1'b0;
    check("rst3_hit_after", bus.forwardHit, 0);

    check("log_size", log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      check($sformatf("order_%0d", i), log_q[i], exp_q[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/store_write_buffer.md
Name: store_write_buffer

Overview:
- Sits directly downstream of the STR ALU stage. It accepts a store as an address/data pair and queues it in a small in-order FIFO.
- It drains the queue to data memory through a valid/ack write port, so the core does not stall on slow memory writes.
- It provides youngest-match store-to-load forwarding so later loads see pending stores.
- It reports empty, for halt/fence logic.

Parameters:
DEPTH, 4, number of buffered stores (power of 2, minimum 2)
PTR_W, 2, pointer width, equals log2(DEPTH)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
storeValid  input  1  STR stage presents a store this cycle
storeAddress  input  16  store address (the STR stage's memoryAddress)
storeData  input  16  store data (the STR stage's memoryOut)
storeReady  output  1  buffer can accept a store this cycle
memWriteEnable  output  1  head entry presented to data memory
memAddress  output  16  head entry address
memData  output  16  head entry data
memAck  input  1  data memory accepted the presented write this cycle
loadAddress  input  16  address of the load in flight
forwardHit  output  1  a buffered store matches loadAddress
forwardData  output  16  data of the youngest matching buffered store
bufferCount  output  PTR_W+1  number of occupied entries
bufferEmpty  output  1  bufferCount == 0

Behaviour:
- Reset (asynchronous, rst_n low):
  - Write pointer, read pointer, count and every entry's address/data/valid clear to 0.
  - Resulting outputs: storeReady=1, memWriteEnable=0, memAddress=0, memData=0, forwardHit=0, forwardData=0, bufferCount=0, bufferEmpty=1.
  - Reset mid-drain discards all pending stores; no write completes after rst_n falls.
- Storage:
  - Circular FIFO with per-entry valid bits; pointers wrap modulo DEPTH.
  - All state updates on the rising clk edge only.
- Enqueue:
  - Occurs when storeValid && storeReady.
  - Writes the entry at the write pointer, sets its valid bit, increments the write pointer.
  - storeReady = (count != DEPTH), purely from registered count. It does NOT depend on memAck, so there is no enqueue-into-full even if the head drains the same cycle.
  - storeValid while storeReady=0 is ignored. Upstream holds the store and retries.
- Memory port:
  - memWriteEnable = !bufferEmpty.
  - memAddress/memData are driven from the head entry's registers (no combinational path from store inputs). They are 0 when empty.
  - Head values stay stable until acknowledged.
  - Dequeue occurs when memWriteEnable && memAck: clears the head valid bit and increments the read pointer.
  - memAck while memWriteEnable=0 is ignored.
- Latency:
  - A store accepted at edge N into an empty buffer appears on memWriteEnable/memAddress/memData after edge N (visible in cycle N+1).
  - Minimum one cycle per write. Back-to-back acks drain one entry per cycle.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance.
  - Count update: +1 on enqueue only, -1 on dequeue only, unchanged on both or neither.
- Ordering: writes issue to memory strictly in acceptance order.
- Forwarding (combinational):
  - Compare loadAddress with every valid entry.
  - forwardHit=1 if any entry matches; forwardData = data of the youngest matching entry (closest to the write pointer). Otherwise forwardHit=0 and forwardData=0.
  - A store being enqueued this same cycle is not visible until after the edge.
  - A head entry being acknowledged this cycle is still visible until the edge.
- Width rules: 16-bit addresses/data pass through unmodified; no alignment or masking.

Test Plan:
- Reset with rst_n=0 mid-run while 3 entries are pending -> immediately memWriteEnable=0, bufferCount=0, storeReady=1, bufferEmpty=1; after release no write to the old addresses appears.
- Single store (addr 0x0040, data 0xBEEF) into empty buffer, memAck held 0 for 3 cycles then 1 -> memWriteEnable=1 from the next cycle with memAddress=0x0040 and memData=0xBEEF held stable; bufferEmpty=1 the cycle after the ack.
- Fill: 4 stores (0x10/0x1111 .. 0x13/0x4444) with memAck=0 -> storeReady=0, bufferCount=4; a 5th storeValid is ignored. Then enqueue a new store and assert memAck in the same cycle -> exactly one write completes, the stalled store is accepted the following cycle, and writes issue in order 0x10, 0x11, 0x12, 0x13, new.
- Wrap-around: 10 stores with memAck permanently 1 -> 10 writes in order with correct address/data pairs and bufferCount never exceeding 1.
- Forwarding: buffer 0x20/0xAAAA, 0x30/0xBBBB, 0x20/0xCCCC with memAck=0; loadAddress=0x20 -> forwardHit=1, forwardData=0xCCCC; loadAddress=0x30 -> 0xBBBB; loadAddress=0x40 -> forwardHit=0, forwardData=0.
- Simultaneous enqueue and dequeue at count=2 -> count stays 2 and the pointers advance.
